ex_btc_utx2_enc: RTL and testbench
==================================

EX_BTC_UTX2_ENC -- requirements
Module: ex_btc_utx2_enc

Interface
REQ-001 Parameter LUMA_MODE, default 0, luma function: 0 = (R+2G+B)>>2, 1 = G only.
REQ-002 Ports: clock, in, 1, sole clock; all state updates on its rising edge.
REQ-003 Ports: reset, in, 1, asynchronous, active-low (0 = reset asserted).
REQ-004 Ports: flush, in, 1, synchronous abort of the current block.
REQ-005 Ports: inValid, in, 1, input pixel valid.
REQ-006 Ports: inReady, out, 1, encoder accepting pixels.
REQ-007 Ports: inPix, in, 32, RGBA32 pixel {A,R,G,B}, 8 bits each; A ignored.
REQ-008 Ports: outValid, out, 1, encoded block valid.
REQ-009 Ports: outReady, in, 1, downstream accepts block.
REQ-010 Ports: outBlk, out, 64, UTX2 opaque block.

Function
REQ-011 Pixels arrive in raster order (index i = y*4+x, 0..15), one per inValid&&inReady cycle.
REQ-012 Three states: LOAD, CLASS, OUT; reset enters LOAD with pixel counter 0.
REQ-013 LOAD: inReady=1; each accepted pixel stores RGB555 (top 5 bits per channel) and 8-bit luma into a 16-entry buffer at counter index.
REQ-014 LOAD tracks Ymin/Ymax and their RGB555 colors; ties keep the first (lowest-index) pixel; pixel 0 initialises both.
REQ-015 Accepting pixel 15 moves to CLASS with counter cleared; inReady=0 outside LOAD.
REQ-016 CLASS: one buffer entry per cycle, 16 cycles; Rng = Ymax-Ymin, d = Y-Ymin, widths sized so 6*d and 5*Rng do not overflow (11 bits).
REQ-017 Level = count of true comparisons among 6d>=Rng, 2d>=Rng, 6d>=5*Rng (0..3); Rng==0 forces level 3 for every pixel.
REQ-018 Level to selector {B,A}: 0->00, 1->10, 2->01, 3->11; B written to outBlk bit 33+2i, A to bit 32+2i.
REQ-019 outBlk[15:0] = {0, ColorA RGB555 of Ymax pixel}; outBlk[31:16] = {0, ColorB RGB555 of Ymin pixel}; bits 15 and 31 always 0 (interpolated opaque mode).
REQ-020 After the 16th CLASS cycle the state becomes OUT and outValid=1; first pixel accept to outValid = 32 cycles.
REQ-021 OUT: outValid and outBlk held stable until outValid&&outReady, then return to LOAD, counter 0, min/max cleared.
REQ-022 outValid=0 in LOAD and CLASS; outBlk undefined-free: holds last value (0 after reset) when outValid=0.
REQ-023 flush in any state: next state LOAD, counter 0, outValid=0, partial block discarded; flush overrides a same-cycle input accept or output handshake.
REQ-024 inValid while inReady=0 has no effect; the upstream holds the pixel.

Reset
REQ-025 reset low asynchronously forces state LOAD, counter 0, outValid 0, outBlk 0, Ymin/Ymax and colors 0; inReady=1 one clock after reset release and from assertion onward.
REQ-026 Reset mid-LOAD/CLASS/OUT discards all work; buffer contents need no reset.

Structure
REQ-027 State encodings and the UTX2 bit-layout constants (selector base bit 32, color fields, mode bits 15/31) live in the shared JX2 definitions package shared with the UTX decoder.
REQ-028 One sub-module, ex_btc_luma8, computes 8-bit luma from RGBA32 per LUMA_MODE; everything else is inline.

Verification
REQ-029 Flat: 16 x 0xFF808080 -> outBlk 0xFFFFFFFF42104210 exactly 32 cycles after first accept.
REQ-030 Extremes: pixel0 0xFF000000, pixel1 0xFF808080, pixel15 0xFFFFFFFF, rest 0xFF000000 -> outBlk 0xC000000400007FFF.
REQ-031 Back-pressure: outReady=0 for 10 cycles in OUT -> outValid/outBlk stable, inReady=0; outReady=1 -> LOAD next cycle, next block encodes correctly.
REQ-032 Flush at pixel 7 of LOAD then 16 x 0xFF808080 -> single output 0xFFFFFFFF42104210; no earlier outValid.
REQ-033 Async reset pulsed mid-CLASS -> outValid 0 immediately, inReady 1, following block encodes as in REQ-030.
REQ-034 Round trip: random blocks encoded, each pixel decoded by the UTX2 extract path -> per-channel error within one interpolation step of source.

Source files
------------

// File: rtl/ex_btc_utx2_enc_pkg.sv
// Definitions shared by the UTX2 encoder and decoder: FSM states, buffer entry
// layout and the bit positions of the 64-bit opaque block.
package ex_btc_utx2_enc_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLASS = 2'd1,
    ST_OUT   = 2'd2
  } enc_state_e;

  localparam int SEL_BASE   = 32;
  localparam int COLA_LSB   = 0;
  localparam int COLB_LSB   = 16;
  localparam int MODE_BIT_A = 15;
  localparam int MODE_BIT_B = 31;

  typedef struct packed {
    logic [14:0] rgb;
    logic [7:0]  luma;
  } pix_ent_t;

  function automatic logic [14:0] rgb555(input logic [31:0] pix);
    return {pix[23:19], pix[15:11], pix[7:3]};
  endfunction

  // Level 0..3 (Ymin..Ymax) to the {B,A} selector pair stored in the block.
  function automatic logic [1:0] level_to_sel(input logic [1:0] lvl);
    logic [1:0] sel;
    case (lvl)
      2'd0:    sel = 2'b00;
      2'd1:    sel = 2'b10;
      2'd2:    sel = 2'b01;
      default: sel = 2'b11;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ex_btc_utx2_enc_if.sv
// Pixel-in / block-out handshake bundle of the UTX2 encoder.
interface ex_btc_utx2_enc_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] inPix;
  logic        outValid;
  logic        outReady;
  logic [63:0] outBlk;

  modport master (output inValid, inPix, outReady, input inReady, outValid, outBlk);
  modport slave  (input inValid, inPix, outReady, output inReady, outValid, outBlk);
endinterface

// File: rtl/ex_btc_utx2_enc_luma8.sv
// 8-bit luma of an RGBA32 pixel: (R+2G+B)>>2, or G alone when LUMA_MODE=1.
module ex_btc_luma8 #(
  parameter int LUMA_MODE = 0
) (
  input  logic [31:0] pix,
  output logic [7:0]  luma
);
  logic [9:0] sum;
  logic       unused_bits;

  assign sum         = {2'b00, pix[23:16]} + {1'b0, pix[15:8], 1'b0} + {2'b00, pix[7:0]};
  assign luma        = (LUMA_MODE == 1) ? pix[15:8] : sum[9:2];
  assign unused_bits = ^{pix[31:24], sum[1:0]};
endmodule

// File: rtl/ex_btc_utx2_enc.sv
// UTX2 opaque block encoder: buffers a 4x4 RGBA32 tile, picks luma extremes as
// endpoints and classifies each pixel into one of four interpolation levels.
module ex_btc_utx2_enc
  import ex_btc_utx2_enc_pkg::*;
#(
  parameter int LUMA_MODE = 0
) (
  input logic               clock,
  input logic               reset,
  input logic               flush,
  ex_btc_utx2_enc_if.slave  bus
);

  enc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  ymin_q, ymin_d, ymax_q, ymax_d;
  logic [14:0] cmin_q, cmin_d, cmax_q, cmax_d;
  logic [31:0] sel_q, sel_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_blk_q, out_blk_d;

  pix_ent_t    buf_q [16];
  logic [7:0]  pix_luma;
  logic [14:0] pix_rgb;
  logic        pix_acc;
  pix_ent_t    cur;
  logic [10:0] rng, d, d6, rng5;
  logic [1:0]  lvl;

  ex_btc_luma8 #(.LUMA_MODE(LUMA_MODE)) u_luma (
    .pix  (bus.inPix),
    .luma (pix_luma)
  );

  assign pix_rgb      = rgb555(bus.inPix);
  assign pix_acc      = in_ready_q & bus.inValid;
  assign bus.inReady  = in_ready_q;
  assign bus.outValid = out_valid_q;
  assign bus.outBlk   = out_blk_q;

  // Widened to 11 bits so 6*d and 5*Rng cannot wrap.
  assign cur  = buf_q[cnt_q];
  assign rng  = {3'b000, ymax_q - ymin_q};
  assign d    = {3'b000, cur.luma - ymin_q};
  assign d6   = (d << 2) + (d << 1);
  assign rng5 = (rng << 2) + rng;
  assign lvl  = (rng == 11'd0) ? 2'd3 :
                {1'b0, d6 >= rng} + {1'b0, (d << 1) >= rng} + {1'b0, d6 >= rng5};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    cmin_d      = cmin_q;
    cmax_d      = cmax_q;
    sel_d       = sel_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_blk_d   = out_blk_q;
    case (state_q)
      ST_LOAD: begin
        if (pix_acc) begin
          if (cnt_q == 4'd0) begin
            ymin_d = pix_luma;
            ymax_d = pix_luma;
            cmin_d = pix_rgb;
            cmax_d = pix_rgb;
          end else begin
            if (pix_luma < ymin_q) begin
              ymin_d = pix_luma;
              cmin_d = pix_rgb;
            end
            if (pix_luma > ymax_q) begin
              ymax_d = pix_luma;
              cmax_d = pix_rgb;
            end
          end
          if (cnt_q == 4'd15) begin
            state_d    = ST_CLASS;
            in_ready_d = 1'b0;
            cnt_d      = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_CLASS: begin
        sel_d[{cnt_q, 1'b0} +: 2] = level_to_sel(lvl);
        if (cnt_q == 4'd15) begin
          state_d                   = ST_OUT;
          cnt_d                     = 4'd0;
          out_valid_d               = 1'b1;
          out_blk_d                 = '0;
          out_blk_d[COLA_LSB +: 15] = cmax_q;
          out_blk_d[COLB_LSB +: 15] = cmin_q;
          out_blk_d[SEL_BASE +: 32] = sel_d;
          out_blk_d[MODE_BIT_A]     = 1'b0;
          out_blk_d[MODE_BIT_B]     = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (bus.outReady) begin
          state_d     = ST_LOAD;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          ymin_d      = '0;
          ymax_d      = '0;
          cmin_d      = '0;
          cmax_d      = '0;
          sel_d       = '0;
        end
      end
      default: begin
        state_d    = ST_LOAD;
        in_ready_d = 1'b1;
      end
    endcase
    // Flush wins over any same-cycle accept or handshake; the last block stays visible.
    if (flush) begin
      state_d     = ST_LOAD;
      cnt_d       = 4'd0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      ymin_d      = '0;
      ymax_d      = '0;
      cmin_d      = '0;
      cmax_d      = '0;
      sel_d       = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      cmin_q      <= '0;
      cmax_q      <= '0;
      sel_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_blk_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cmin_q      <= cmin_d;
      cmax_q      <= cmax_d;
      sel_q       <= sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_blk_q   <= out_blk_d;
    end
  end

  always_ff @(posedge clock) begin
    if (pix_acc && !flush) buf_q[cnt_q] <= '{rgb: pix_rgb, luma: pix_luma};
  end

endmodule

// File: tb/tb_ex_btc_utx2_enc.sv
// Scoreboard bench for the UTX2 encoder: directed tiles plus random round trips.
module tb_ex_btc_utx2_enc;

  localparam logic [63:0] FLAT_BLK = 64'hFFFF_FFFF_4210_4210;
  localparam logic [63:0] EXTR_BLK = 64'hC000_0004_0000_7FFF;
  localparam logic [63:0] TIE_BLK  = 64'hFFFF_FFFF_2108_2108;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  ex_btc_utx2_enc_if bus_if ();

  ex_btc_utx2_enc #(.LUMA_MODE(0)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk  = 0;
  int n_pass = 0;
  int first_acc = 0;
  bit first_pend = 1'b0;

  typedef struct {
    logic [63:0]  blk;
    bit           rt;
    logic [511:0] px;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [14:0] c555(input logic [31:0] p);
    return {p[23:19], p[15:11], p[7:3]};
  endfunction

  function automatic int luma_of(input logic [31:0] p);
    return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
  endfunction

  // Reference encoder used for random tiles.
  function automatic logic [63:0] model_blk(input logic [511:0] px);
    logic [63:0] blk;
    int y[16];
    int imn, imx, rng, dd, lvl;
    blk = '0;
    for (int i = 0; i < 16; i++) y[i] = luma_of(px[i*32 +: 32]);
    imn = 0;
    imx = 0;
    for (int i = 1; i < 16; i++) begin
      if (y[i] < y[imn]) imn = i;
      if (y[i] > y[imx]) imx = i;
    end
    rng = y[imx] - y[imn];
    for (int i = 0; i < 16; i++) begin
      dd = y[i] - y[imn];
      if (rng == 0) lvl = 3;
      else lvl = int'(6 * dd >= rng) + int'(2 * dd >= rng) + int'(6 * dd >= 5 * rng);
      blk[33 + 2*i] = (lvl == 1) || (lvl == 3);
      blk[32 + 2*i] = (lvl == 2) || (lvl == 3);
    end
    blk[14:0]  = c555(px[imx*32 +: 32]);
    blk[30:16] = c555(px[imn*32 +: 32]);
    return blk;
  endfunction

  // Decode every pixel of a gray tile and bound its error against the source.
  task automatic round_trip(input logic [511:0] px, input logic [63:0] blk);
    int vmin, vmax, tol, lvl, a5, b5, ea, eb, dec, src, err, worst;
    vmin = 255;
    vmax = 0;
    for (int i = 0; i < 16; i++) begin
      src = int'(px[i*32 + 8 +: 8]);
      if (src < vmin) vmin = src;
      if (src > vmax) vmax = src;
    end
    tol = (vmax - vmin) / 3 + 9;
    for (int i = 0; i < 16; i++) begin
      case ({blk[33 + 2*i], blk[32 + 2*i]})
        2'b00:   lvl = 0;
        2'b10:   lvl = 1;
        2'b01:   lvl = 2;
        default: lvl = 3;
      endcase
      worst = 0;
      for (int ch = 0; ch < 3; ch++) begin
        a5  = int'(blk[5*ch +: 5]);
        b5  = int'(blk[16 + 5*ch +: 5]);
        ea  = (a5 << 3) | (a5 >> 2);
        eb  = (b5 << 3) | (b5 >> 2);
        dec = (eb * (3 - lvl) + ea * lvl) / 3;
        src = int'(px[i*32 + 8*ch +: 8]);
        err = (dec > src) ? dec - src : src - dec;
        if (err > worst) worst = err;
      end
      n_chk++;
      if (worst <= tol) n_pass++;
      else $display("FAIL rt_pix%0d: error %0d, allowed at most %0d", i, worst, tol);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && bus_if.outValid && bus_if.outReady && !flush) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got block %h, none expected (t=%0t)", bus_if.outBlk, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_blk", bus_if.outBlk, e.blk);
        if (e.rt) round_trip(e.px, bus_if.outBlk);
      end
    end
  end

  task automatic push_exp(input logic [63:0] blk, input bit rt, input logic [511:0] px);
    exp_t e;
    e.blk = blk;
    e.rt  = rt;
    e.px  = px;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_px(input logic [31:0] p);
    int n = 0;
    bus_if.inValid = 1'b1;
    bus_if.inPix   = p;
    @(negedge clock);
    while (!bus_if.inReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus_if.inReady) chk("in_ready_timeout", {63'd0, bus_if.inReady}, 64'd1);
    if (first_pend) begin
      first_acc  = cyc + 1;
      first_pend = 1'b0;
    end
    @(posedge clock);
    #1;
    bus_if.inValid = 1'b0;
  endtask

  task automatic send_blk(input logic [511:0] px);
    first_pend = 1'b1;
    for (int i = 0; i < 16; i++) send_px(px[i*32 +: 32]);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clock);
    while (!bus_if.outValid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus_if.outValid) chk("out_valid_timeout", {63'd0, bus_if.outValid}, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  logic [511:0] flat_px, extr_px, tie_px, rnd_px;

  initial begin
    bus_if.inValid  = 1'b0;
    bus_if.inPix    = '0;
    bus_if.outReady = 1'b1;
    flat_px = {16{32'hFF80_8080}};
    extr_px = {16{32'hFF00_0000}};
    extr_px[1*32 +: 32]  = 32'hFF80_8080;
    extr_px[15*32 +: 32] = 32'hFFFF_FFFF;
    tie_px = {16{32'hFF40_4040}};
    tie_px[1*32 +: 32] = 32'hFF00_8000;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", {63'd0, bus_if.inReady}, 64'd1);
    chk("rst_out_valid", {63'd0, bus_if.outValid}, 64'd0);
    chk("rst_out_blk", bus_if.outBlk, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", {63'd0, bus_if.inReady}, 64'd1);

    // flat tile and first-accept-to-valid latency
    push_exp(FLAT_BLK, 1'b0, flat_px);
    send_blk(flat_px);
    wait_valid();
    chk("latency", 64'(cyc - first_acc + 1), 64'd32);
    wait_idle();

    push_exp(EXTR_BLK, 1'b0, extr_px);
    send_blk(extr_px);
    wait_idle();

    push_exp(TIE_BLK, 1'b0, tie_px);
    send_blk(tie_px);
    wait_idle();

    // back-pressure in OUT
    bus_if.outReady = 1'b0;
    push_exp(FLAT_BLK, 1'b0, flat_px);
    send_blk(flat_px);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", {63'd0, bus_if.outValid}, 64'd1);
      chk("bp_out_blk", bus_if.outBlk, FLAT_BLK);
      chk("bp_in_ready", {63'd0, bus_if.inReady}, 64'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    bus_if.outReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_release_in_ready", {63'd0, bus_if.inReady}, 64'd1);
    chk("bp_release_out_valid", {63'd0, bus_if.outValid}, 64'd0);
    @(posedge clock);
    #1;
    push_exp(EXTR_BLK, 1'b0, extr_px);
    send_blk(extr_px);
    wait_idle();

    // flush coinciding with pixel 7 of a black partial tile
    for (int i = 0; i < 7; i++) send_px(32'hFF00_0000);
    flush = 1'b1;
    bus_if.inValid = 1'b1;
    bus_if.inPix   = 32'hFF00_0000;
    @(posedge clock);
    #1;
    flush = 1'b0;
    bus_if.inValid = 1'b0;
    push_exp(FLAT_BLK, 1'b0, flat_px);
    send_blk(flat_px);
    wait_idle();

    // asynchronous reset in the middle of CLASS
    send_blk(flat_px);
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus_if.outValid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus_if.inReady}, 64'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    push_exp(EXTR_BLK, 1'b0, extr_px);
    send_blk(extr_px);
    wait_idle();

    // random gray tiles with round-trip decode
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        rnd_px[i*32 +: 32] = {8'hFF, v, v, v};
      end
      push_exp(model_blk(rnd_px), 1'b1, rnd_px);
      send_blk(rnd_px);
      wait_idle();
    end

    // random colored tiles against the reference encoder
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) rnd_px[i*32 +: 32] = {8'($urandom), 24'($urandom)};
      push_exp(model_blk(rnd_px), 1'b0, rnd_px);
      send_blk(rnd_px);
      wait_idle();
    end

    repeat (5) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
